// File: rtl/ped_req_pkg.sv
// ped_req_pkg: shared FSM state, default button count and index-width helper
// for the pedestrian request controller.
package ped_req_pkg;
    typedef enum logic {IDLE, PRESENT} state_t;
    localparam int NUM_BTN_DEF = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int IDX_W = idx_w(NUM_BTN_DEF);
endpackage

// File: rtl/ped_request_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stable-count debouncer for one button.
module btn_debounce
    import ped_req_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync1, sync2;
    logic [CW-1:0] cnt;
    always_ff @(posedge sclk or negedge rst_n)
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
endmodule

// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: debounced push-button requests, round-robin handed to the light sequencer.
// Optional request expiry enabled by defining PED_REQ_TIMEOUT_EN.
module ped_request_ctrl
    import ped_req_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int TIMEOUT_CYCLES  = 96000000
) (
    input  logic                        sclk,
    input  logic                        rst_n,
    input  logic [NUM_BTN-1:0]          btn_raw,
    output logic [NUM_BTN-1:0]          btn_level,
    output logic [NUM_BTN-1:0]          pending,
    output logic                        req_valid,
    output logic [idx_w(NUM_BTN)-1:0]   req_idx,
    input  logic                        req_ready,
    output logic                        req_dropped
);
    localparam int IW = idx_w(NUM_BTN);
    state_t state;
    logic [NUM_BTN-1:0] level_d, rise, clr;
    logic [IW-1:0] rr_ptr, pick, nxt;
    logic found, accept, expire;
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .sclk (sclk),
            .rst_n(rst_n),
            .raw  (btn_raw[g]),
            .level(btn_level[g])
        );
    end
    // Scan downward so the closest set bit at or after rr_ptr is the last one written.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_BTN) j = j - NUM_BTN;
            if (pending[j]) begin
                found = 1'b1;
                pick  = j[IW-1:0];
            end
        end
    end
    assign rise   = btn_level & ~level_d;
    assign accept = (state == PRESENT) && req_ready;
    assign nxt    = (req_idx == IW'(NUM_BTN - 1)) ? '0 : req_idx + IW'(1);
    assign clr    = (accept || expire) ? (NUM_BTN'(1) << req_idx) : '0;
`ifdef PED_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    assign expire = (state == PRESENT) && !req_ready && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign expire      = 1'b0;
    assign req_dropped = 1'b0;
`endif
    always_ff @(posedge sclk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_idx   <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
            level_d   <= '0;
`ifdef PED_REQ_TIMEOUT_EN
            tcnt        <= '0;
            req_dropped <= 1'b0;
`endif
        end else begin
            level_d <= btn_level;
            pending <= (pending & ~clr) | rise;
`ifdef PED_REQ_TIMEOUT_EN
            req_dropped <= expire;
            tcnt        <= (state == PRESENT && !accept && !expire) ? tcnt + TW'(1) : '0;
`endif
            case (state)
                IDLE:
                    if (found) begin
                        req_idx   <= pick;
                        req_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                default:
                    if (accept || expire) begin
                        req_valid <= 1'b0;
                        rr_ptr    <= nxt;
                        state     <= IDLE;
                    end
            endcase
        end
endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb_ped_request_ctrl: directed checks of debounce, round-robin hand-off, hold, timeout and reset.
module tb_ped_request_ctrl;
    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_level, pending;
    logic req_valid, req_ready = 1'b0, req_dropped;
    logic [1:0] req_idx;
    int checks = 0, errors = 0;

    ped_request_ctrl #(.NUM_BTN(4), .DEBOUNCE_CYCLES(8), .TIMEOUT_CYCLES(20)) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .pending    (pending),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .req_dropped(req_dropped)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!req_valid && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(req_valid), 1);
    endtask

    initial begin
        logic [1:0] order [3];
        int got;
        bit stable;
        #3;
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_idx", 32'(req_idx), 0);
        chk("rst_dropped", 32'(req_dropped), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // single press: level after 10 edges, pending after 11, valid after 12, accept at 13
        req_ready = 1'b1;
        btn_raw[2] = 1'b1;
        tick(9);
        chk("press_level_early", 32'(btn_level), 0);
        tick();
        chk("press_level", 32'(btn_level), 4'b0100);
        chk("press_pending_early", 32'(pending), 0);
        tick();
        chk("press_pending", 32'(pending), 4'b0100);
        chk("press_valid_early", 32'(req_valid), 0);
        tick();
        chk("press_valid", 32'(req_valid), 1);
        chk("press_idx", 32'(req_idx), 2);
        tick();
        chk("press_accept_valid", 32'(req_valid), 0);
        chk("press_accept_pending", 32'(pending), 0);
        btn_raw[2] = 1'b0;
        tick(12);
        chk("release_level", 32'(btn_level), 0);
        chk("release_pending", 32'(pending), 0);
        chk("release_valid", 32'(req_valid), 0);

        // bounce shorter than the debounce window never registers
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            tick(3);
        end
        tick(12);
        chk("bounce_level", 32'(btn_level), 0);
        chk("bounce_pending", 32'(pending), 0);
        chk("bounce_valid", 32'(req_valid), 0);

        // round robin from rr_ptr=0 over pending 1011
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_ready = 1'b0;
        btn_raw = 4'b1011;
        tick(11);
        chk("rr_pending", 32'(pending), 4'b1011);
        req_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_valid && got < 3) begin
                order[got] = req_idx;
                got++;
            end
            tick();
        end
        chk("rr_count", 32'(got), 3);
        chk("rr_first", 32'(order[0]), 0);
        chk("rr_second", 32'(order[1]), 1);
        chk("rr_third", 32'(order[2]), 3);
        chk("rr_pending_done", 32'(pending), 0);
        btn_raw = '0;
        req_ready = 1'b0;
        tick(12);

        // hold with ready low, rr_ptr now 0 so button 1 is next
        btn_raw[1] = 1'b1;
        wait_valid("hold_wait");
        btn_raw[1] = 1'b0;
        chk("hold_idx", 32'(req_idx), 1);
        stable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!req_valid || req_idx != 2'd1) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 1);
        req_ready = 1'b1;
        tick();
        chk("hold_accept_valid", 32'(req_valid), 0);
        chk("hold_accept_pending", 32'(pending), 0);
        tick(3);
        chk("hold_single", 32'(req_valid), 0);
        req_ready = 1'b0;
        tick(12);

        // expiry behaviour, rr_ptr now 2
        btn_raw[2] = 1'b1;
        wait_valid("to_wait");
        btn_raw[2] = 1'b0;
        chk("to_idx", 32'(req_idx), 2);
`ifdef PED_REQ_TIMEOUT_EN
        tick(19);
        chk("to_valid_before", 32'(req_valid), 1);
        chk("to_dropped_before", 32'(req_dropped), 0);
        tick();
        chk("to_valid_after", 32'(req_valid), 0);
        chk("to_dropped_pulse", 32'(req_dropped), 1);
        chk("to_pending", 32'(pending), 0);
        tick();
        chk("to_dropped_end", 32'(req_dropped), 0);
        tick(12);
        btn_raw[3] = 1'b1;
        wait_valid("mid_wait");
        btn_raw[3] = 1'b0;
`else
        tick(100);
        chk("noto_valid", 32'(req_valid), 1);
        chk("noto_idx", 32'(req_idx), 2);
        chk("noto_dropped", 32'(req_dropped), 0);
`endif

        // reset while presenting discards the request silently
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(req_valid), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_idx", 32'(req_idx), 0);
        chk("mid_rst_dropped", 32'(req_dropped), 0);
        tick();
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_valid", 32'(req_valid), 0);
        chk("post_rst_dropped", 32'(req_dropped), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
